// File: rtl/interrupt_dispatcher.sv
// interrupt_dispatcher: fixed-priority request/ack/return handshake for 4 latched switch interrupts.
// Define INT_MASK_EN to add a writable per-source mask register (otherwise all sources enabled).
module interrupt_dispatcher #(
   parameter int VEC_W = 16,
   parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'('h0100),
   parameter logic [VEC_W-1:0] VEC_STRIDE = VEC_W'('h0010)
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic [3:0]       Pending,
   input  logic             GIE,
   input  logic             IntAck,
   input  logic             Reti,
   input  logic             MaskWrite,
   input  logic [3:0]       MaskIn,
   output logic             IRQ,
   output logic [VEC_W-1:0] Vector,
   output logic [1:0]       ActiveId,
   output logic [3:0]       ClrSrc,
   output logic             Busy
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
   state_t state, state_n;
   logic [3:0] mask, elig, clr_n;
   logic [1:0] sel, id_n;
   logic [VEC_W-1:0] vec_n;
   logic irq_n, busy_n;
`ifdef INT_MASK_EN
   always_ff @(posedge CLK)
      if (CLR) mask <= 4'b1111;
      else if (MaskWrite) mask <= MaskIn;
`else
   logic unused_mask;
   assign unused_mask = ^{MaskWrite, MaskIn};
   assign mask = 4'b1111;
`endif
   assign elig = Pending & mask;
   assign sel = elig[0] ? 2'd0 : elig[1] ? 2'd1 : elig[2] ? 2'd2 : 2'd3;
   always_comb begin
      state_n = state;
      irq_n = IRQ;
      vec_n = Vector;
      id_n = ActiveId;
      clr_n = 4'b0000;
      busy_n = Busy;
      case (state)
         IDLE:
            if (GIE && elig != 4'b0000) begin
               id_n = sel;
               vec_n = VEC_BASE + VEC_STRIDE * VEC_W'(sel);
               irq_n = 1'b1;
               state_n = REQ;
            end
         REQ:
            if (IntAck) begin
               irq_n = 1'b0;
               clr_n = 4'b0001 << ActiveId;
               busy_n = 1'b1;
               state_n = SERVICE;
            end else if (!GIE) begin
               irq_n = 1'b0;
               state_n = IDLE;
            end
         SERVICE:
            if (Reti) begin
               busy_n = 1'b0;
               state_n = IDLE;
            end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK)
      if (CLR) begin
         state <= IDLE;
         IRQ <= 1'b0;
         Vector <= '0;
         ActiveId <= 2'd0;
         ClrSrc <= 4'b0000;
         Busy <= 1'b0;
      end else begin
         state <= state_n;
         IRQ <= irq_n;
         Vector <= vec_n;
         ActiveId <= id_n;
         ClrSrc <= clr_n;
         Busy <= busy_n;
      end
endmodule
